riscv_tag_exception_unit: RTL and testbench

// - Consumer side of the tag-check exception path: captures each tag-check violation
//   (which operand tripped plus PC) into a small queue.
// - Presents queued violations one at a time to the controller as an interrupt request

---
 rtl/riscv_tag_exception_unit.sv | 145 ++++++++++++++
 tb/tb_riscv_tag_exception_unit.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/riscv_tag_exception_unit.sv
// Tag-check exception queue: buffers EX-stage violations and presents them one at a time
// to the controller as a req/ack interrupt. Optional violation counter under TAG_EXC_CNT_EN.
module riscv_tag_exception_unit #(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned PC_WIDTH = 32,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                exc_i,
    input  logic                exc_s1_i,
    input  logic                exc_s2_i,
    input  logic                exc_d_i,
    input  logic [PC_WIDTH-1:0] exc_pc_i,
    input  logic                irq_ack_i,
    input  logic                clr_i,
    output logic                irq_req_o,
    output logic [2:0]          cause_o,
    output logic [PC_WIDTH-1:0] epc_o,
    output logic                overflow_o,
    output logic [CNT_W-1:0]    exc_cnt_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    typedef struct packed {
        logic [2:0]          cause;
        logic [PC_WIDTH-1:0] pc;
    } entry_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        GAP  = 2'd2
    } state_t;

    entry_t              mem_q [DEPTH];
    logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
    state_t              state_q;
    logic                irq_req_q;
    logic [2:0]          cause_q;
    logic [PC_WIDTH-1:0] epc_q;
    logic                overflow_q;

    logic   full_c, empty_c, pop_c, push_c, drop_c;
    entry_t head_c, new_c;

    // Extra pointer MSB distinguishes full from empty when the low bits match
    assign full_c  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_c = (wr_ptr_q == rd_ptr_q);
    assign pop_c   = (state_q == REQ) && irq_ack_i;
    assign push_c  = exc_i && (!full_c || pop_c);
    assign drop_c  = exc_i && full_c && !pop_c;
    assign head_c  = mem_q[rd_ptr_q[AW-1:0]];
    assign new_c   = '{cause: {exc_d_i, exc_s2_i, exc_s1_i}, pc: exc_pc_i};

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_c) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop_c)  rd_ptr_d = rd_ptr_q + PW'(1);
    end

    // Storage needs no reset; the pointers define validity. A full push+pop overwrites
    // the head slot, which is safe because the head is already latched in cause_q/epc_q.
    always_ff @(posedge clk) begin
        if (push_c) mem_q[wr_ptr_q[AW-1:0]] <= new_c;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            if (drop_c)     overflow_q <= 1'b1;
            else if (clr_i) overflow_q <= 1'b0;
        end
    end

    // Handshake FSM; GAP forces one deasserted cycle between consecutive events
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            irq_req_q <= 1'b0;
            cause_q   <= '0;
            epc_q     <= '0;
        end else begin
            case (state_q)
                IDLE, GAP: begin
                    if (!empty_c) begin
                        state_q   <= REQ;
                        irq_req_q <= 1'b1;
                        cause_q   <= head_c.cause;
                        epc_q     <= head_c.pc;
                    end else begin
                        state_q   <= IDLE;
                    end
                end
                REQ: begin
                    if (irq_ack_i) begin
                        state_q   <= GAP;
                        irq_req_q <= 1'b0;
                        cause_q   <= '0;
                        epc_q     <= '0;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    irq_req_q <= 1'b0;
                    cause_q   <= '0;
                    epc_q     <= '0;
                end
            endcase
        end
    end

`ifdef TAG_EXC_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= CNT_W'(exc_i);
        end else if (exc_i && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign exc_cnt_o = cnt_q;
`else
    assign exc_cnt_o = '0;
`endif

    assign irq_req_o  = irq_req_q;
    assign cause_o    = cause_q;
    assign epc_o      = epc_q;
    assign overflow_o = overflow_q;

endmodule

// File: tb/tb_riscv_tag_exception_unit.sv
// Directed self-checking bench for riscv_tag_exception_unit (DEPTH=4, PC_WIDTH=32, CNT_W=16).
module tb_riscv_tag_exception_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        exc_i, exc_s1_i, exc_s2_i, exc_d_i;
    logic [31:0] exc_pc_i;
    logic        irq_ack_i, clr_i;
    logic        irq_req_o;
    logic [2:0]  cause_o;
    logic [31:0] epc_o;
    logic        overflow_o;
    logic [15:0] exc_cnt_o;

    int n_assert = 0;
    int n_fail   = 0;

    riscv_tag_exception_unit #(.DEPTH(4), .PC_WIDTH(32), .CNT_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .exc_i      (exc_i),
        .exc_s1_i   (exc_s1_i),
        .exc_s2_i   (exc_s2_i),
        .exc_d_i    (exc_d_i),
        .exc_pc_i   (exc_pc_i),
        .irq_ack_i  (irq_ack_i),
        .clr_i      (clr_i),
        .irq_req_o  (irq_req_o),
        .cause_o    (cause_o),
        .epc_o      (epc_o),
        .overflow_o (overflow_o),
        .exc_cnt_o  (exc_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One capture edge with the given PC and cause {d,s2,s1}
    task automatic push(input logic [31:0] pc, input logic [2:0] c);
        exc_i    = 1'b1;
        exc_pc_i = pc;
        exc_d_i  = c[2];
        exc_s2_i = c[1];
        exc_s1_i = c[0];
        step();
        exc_i    = 1'b0;
        exc_d_i  = 1'b0;
        exc_s2_i = 1'b0;
        exc_s1_i = 1'b0;
    endtask

    task automatic ack();
        irq_ack_i = 1'b1;
        step();
        irq_ack_i = 1'b0;
    endtask

    initial begin
        logic [2:0]  causes [4];
        logic [31:0] exp_cnt;
        causes[0] = 3'b001; causes[1] = 3'b100; causes[2] = 3'b000; causes[3] = 3'b111;

        rst_n = 1'b0; exc_i = 1'b0; exc_s1_i = 1'b0; exc_s2_i = 1'b0; exc_d_i = 1'b0;
        exc_pc_i = '0; irq_ack_i = 1'b0; clr_i = 1'b0;
        step(); step();
        rst_n = 1'b1;
        chk("reset_irq", 32'(irq_req_o), 32'd0);
        chk("reset_cause", 32'(cause_o), 32'd0);
        chk("reset_epc", epc_o, 32'd0);
        chk("reset_ovf", 32'(overflow_o), 32'd0);
        chk("reset_cnt", 32'(exc_cnt_o), 32'd0);

        // Single event and capture latency
        push(32'h100, 3'b010);
        chk("lat_irq_low", 32'(irq_req_o), 32'd0);
        step();
        chk("single_irq", 32'(irq_req_o), 32'd1);
        chk("single_cause", 32'(cause_o), 32'd2);
        chk("single_epc", epc_o, 32'h100);

        // Second event queued behind, then ack/gap/re-raise
        push(32'h104, 3'b001);
        chk("hold_irq", 32'(irq_req_o), 32'd1);
        chk("hold_epc", epc_o, 32'h100);
        ack();
        chk("gap_irq", 32'(irq_req_o), 32'd0);
        chk("gap_cause", 32'(cause_o), 32'd0);
        chk("gap_epc", epc_o, 32'd0);
        step();
        chk("second_irq", 32'(irq_req_o), 32'd1);
        chk("second_cause", 32'(cause_o), 32'd1);
        chk("second_epc", epc_o, 32'h104);
        ack();
        step();
        chk("drained_irq", 32'(irq_req_o), 32'd0);
        step();
        chk("idle_irq", 32'(irq_req_o), 32'd0);

        // Overflow: 5 events, no ack
        for (int i = 1; i <= 4; i++) push(32'(i), causes[i-1]);
        chk("full_no_ovf", 32'(overflow_o), 32'd0);
        push(32'd5, 3'b010);
        chk("ovf_set", 32'(overflow_o), 32'd1);
        for (int i = 1; i <= 4; i++) begin
            chk("drain_irq", 32'(irq_req_o), 32'd1);
            chk("drain_epc", epc_o, 32'(i));
            chk("drain_cause", 32'(cause_o), 32'(causes[i-1]));
            ack();
            chk("drain_gap", 32'(irq_req_o), 32'd0);
            step();
        end
        chk("fifth_lost", 32'(irq_req_o), 32'd0);
        chk("ovf_sticky", 32'(overflow_o), 32'd1);
        clr_i = 1'b1;
        step();
        clr_i = 1'b0;
        chk("ovf_clr", 32'(overflow_o), 32'd0);

        // Full with simultaneous push and ack: no overflow, new event retrieved last
        for (int i = 0; i < 4; i++) push(32'h10 + 32'(i), 3'b001);
        chk("full2_irq", 32'(irq_req_o), 32'd1);
        chk("full2_epc", epc_o, 32'h10);
        irq_ack_i = 1'b1;
        push(32'h20, 3'b100);
        irq_ack_i = 1'b0;
        chk("pushpop_ovf", 32'(overflow_o), 32'd0);
        chk("pushpop_gap", 32'(irq_req_o), 32'd0);
        step();
        for (int i = 0; i < 3; i++) begin
            chk("pp_epc", epc_o, 32'h11 + 32'(i));
            ack();
            step();
        end
        chk("pp_last_epc", epc_o, 32'h20);
        chk("pp_last_cause", 32'(cause_o), 32'd4);
        ack();
        step();
        chk("pp_empty", 32'(irq_req_o), 32'd0);

        // Same-cycle clr and new overflow: overflow wins
        for (int i = 0; i < 4; i++) push(32'h30 + 32'(i), 3'b010);
        clr_i = 1'b1;
        push(32'h34, 3'b010);
        clr_i = 1'b0;
        chk("clr_vs_ovf", 32'(overflow_o), 32'd1);

        // Reset mid-handshake with 3 queued
        ack();
        step();
        chk("pre_rst_irq", 32'(irq_req_o), 32'd1);
        chk("pre_rst_epc", epc_o, 32'h31);
        rst_n = 1'b0;
        irq_ack_i = 1'b1;
        push(32'h99, 3'b111);
        irq_ack_i = 1'b0;
        rst_n = 1'b1;
        chk("rst_irq", 32'(irq_req_o), 32'd0);
        chk("rst_cause", 32'(cause_o), 32'd0);
        chk("rst_epc", epc_o, 32'd0);
        chk("rst_ovf", 32'(overflow_o), 32'd0);
        chk("rst_cnt", 32'(exc_cnt_o), 32'd0);
        step(); step();
        chk("rst_no_spurious", 32'(irq_req_o), 32'd0);

        // Ack outside REQ ignored; 6 events for the counter
        irq_ack_i = 1'b1;
        push(32'h40, 3'b011);
        irq_ack_i = 1'b0;
        for (int i = 1; i < 6; i++) push(32'h40 + 32'(i), 3'b001);
        chk("cnt_head_epc", epc_o, 32'h40);
        chk("cnt_head_cause", 32'(cause_o), 32'd3);
        chk("cnt_ovf", 32'(overflow_o), 32'd1);
`ifdef TAG_EXC_CNT_EN
        exp_cnt = 32'd6;
`else
        exp_cnt = 32'd0;
`endif
        chk("cnt_six", 32'(exc_cnt_o), exp_cnt);
        clr_i = 1'b1;
        push(32'h50, 3'b001);
        clr_i = 1'b0;
`ifdef TAG_EXC_CNT_EN
        exp_cnt = 32'd1;
`else
        exp_cnt = 32'd0;
`endif
        chk("cnt_clr_exc", 32'(exc_cnt_o), exp_cnt);
        chk("clr_with_drop", 32'(overflow_o), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
